// File: rtl/ysyx_23060171_ifu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ysyx_23060171_ifu : PC owner and fetch FSM for the multicycle core.          |
// | Optional: YSYX_23060171_IFU_PERF_EN adds fetch/wait performance counters.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module ysyx_23060171_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ERR_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus_4D,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        irq,
  input  logic [31:0] mtvec,
  input  logic        mret,
  input  logic [31:0] mepc,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic        fetch_err
`ifdef YSYX_23060171_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cyc
`endif
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        err_q, err_d;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (arready)    state_d = S_WAIT;
      S_WAIT:  if (rvalid)     state_d = S_HOLD;
      S_HOLD:  if (inst_ready) state_d = S_REQ;
      default:                 state_d = S_REQ;
    endcase
  end

  // Handshake strobes depend on state only, never on an input.
  always_comb begin
    arvalid    = (state_q == S_REQ);
    rready     = (state_q == S_WAIT);
    inst_valid = (state_q == S_HOLD);
    araddr     = pc_q;
    inst       = inst_q;
    pcD        = pcd_q;
    pc_plus_4D = pcp4_q;
    fetch_err  = err_q;
  end

  always_comb begin
    if (irq) begin
      redirect_pc = mtvec;
    end else if (mret) begin
      redirect_pc = mepc;
    end else if (jump_valid) begin
      redirect_pc = jump_target;
    end else begin
      redirect_pc = pc_q + 32'd4;
    end
    next_pc = redirect_pc & 32'hFFFF_FFFC;
  end

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    pcd_d  = pcd_q;
    pcp4_d = pcp4_q;
    err_d  = err_q;
    if (state_q == S_WAIT && rvalid) begin
      inst_d = (rresp != 2'b00) ? ERR_INST : rdata;
      pcd_d  = pc_q;
      pcp4_d = pc_q + 32'd4;
      err_d  = err_q | (rresp != 2'b00);
    end
    if (state_q == S_HOLD && inst_ready) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= 32'd0;
      pcd_q  <= RESET_PC;
      pcp4_q <= RESET_PC + 32'd4;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      pcd_q  <= pcd_d;
      pcp4_q <= pcp4_d;
      err_q  <= err_d;
    end
  end

`ifdef YSYX_23060171_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [63:0] perf_wait_cyc_q, perf_wait_cyc_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_wait_cyc_d  = perf_wait_cyc_q;
    if (state_q == S_HOLD && inst_ready) begin
      perf_fetch_cnt_d = perf_fetch_cnt_q + 64'd1;
    end
    if (state_q == S_WAIT && !rvalid) begin
      perf_wait_cyc_d = perf_wait_cyc_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_q <= 64'd0;
      perf_wait_cyc_q  <= 64'd0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_wait_cyc_q  <= perf_wait_cyc_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_wait_cyc  = perf_wait_cyc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060171_ifu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ysyx_23060171_ifu : scripted per-instruction fetch bench with a model.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_ysyx_23060171_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] inst, pcD, pc_plus_4D;
  logic        inst_valid, inst_ready;
  logic        irq, mret, jump_valid;
  logic [31:0] mtvec, mepc, jump_target;
  logic        fetch_err;

  always #5 clk = ~clk;

  ysyx_23060171_ifu dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pcD(pcD), .pc_plus_4D(pc_plus_4D),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .irq(irq), .mtvec(mtvec), .mret(mret), .mepc(mepc),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .fetch_err(fetch_err)
  );

  int n_pass = 0;
  int n_total = 0;

  // Architectural view of the fetch unit: PC, last delivered word, sticky error.
  logic [31:0] m_pc, m_inst, m_pcd;
  logic        m_err;

  // Values observed during the most recent fetch, for literal pinning.
  logic [31:0] q_araddr0, h_inst, h_pcd, h_p4;
  int          h_at;
  bit          force_jv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%08h required=%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    irq         = 1'($urandom_range(0, 1));
    mret        = 1'($urandom_range(0, 1));
    jump_valid  = force_jv ? 1'b1 : 1'($urandom_range(0, 1));
    mtvec       = $urandom;
    mepc        = $urandom;
    jump_target = $urandom;
    inst_ready  = 1'($urandom_range(0, 1));
    arready     = 1'($urandom_range(0, 1));
    rvalid      = 1'($urandom_range(0, 1));
    rdata       = $urandom;
    rresp       = 2'($urandom_range(0, 3));
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_inst = 32'd0;
    m_pcd  = RST_PC;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    noise();
    tick();
    tick();
    @(negedge clk);
    chk("rst_araddr", araddr, RST_PC);
    chk("rst_arvalid", arvalid, 1);
    chk("rst_rready", rready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pcD", pcD, RST_PC);
    chk("rst_pc_plus_4D", pc_plus_4D, RST_PC + 32'd4);
    chk("rst_fetch_err", fetch_err, 0);
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One instruction: da cycles of arready stall, dr of rvalid stall, dh of
  // inst_ready stall; the redirect arguments apply only in the handshake cycle.
  task automatic do_fetch(input int da, input int dr, input int dh,
                          input logic [31:0] data, input logic [1:0] resp,
                          input logic r_irq, input logic r_mret, input logic r_jv,
                          input logic [31:0] r_mtvec, input logic [31:0] r_mepc,
                          input logic [31:0] r_jt, input bit abort);
    int cyc;
    logic [31:0] sel;
    cyc = 0;
    for (int i = 0; i <= da; i++) begin
      noise();
      arready = (i == da);
      @(negedge clk);
      if (i == 0) q_araddr0 = araddr;
      chk("req_arvalid", arvalid, 1);
      chk("req_araddr", araddr, m_pc);
      chk("req_rready", rready, 0);
      chk("req_inst_valid", inst_valid, 0);
      chk("req_fetch_err", fetch_err, m_err);
      tick();
      cyc++;
    end
    for (int j = 0; j <= dr; j++) begin
      noise();
      rvalid = (j == dr);
      if (j == dr) begin
        rdata = data;
        rresp = resp;
      end
      if (abort) begin
        rst    = 1'b1;
        rvalid = 1'b0;
      end
      @(negedge clk);
      chk("wait_arvalid", arvalid, 0);
      chk("wait_rready", rready, 1);
      chk("wait_inst_valid", inst_valid, 0);
      chk("wait_fetch_err", fetch_err, m_err);
      tick();
      cyc++;
      if (abort) begin
        rst = 1'b0;
        noise();
        arready = 1'b0;
        rvalid  = 1'b1;
        model_reset();
        @(negedge clk);
        chk("abort_araddr", araddr, RST_PC);
        chk("abort_arvalid", arvalid, 1);
        chk("abort_rready", rready, 0);
        chk("abort_inst_valid", inst_valid, 0);
        chk("abort_fetch_err", fetch_err, 0);
        tick();
        return;
      end
    end
    m_inst = (resp != 2'b00) ? EBREAK : data;
    m_pcd  = m_pc;
    m_err  = m_err | (resp != 2'b00);
    h_at   = cyc;
    for (int k = 0; k <= dh; k++) begin
      noise();
      inst_ready = (k == dh);
      if (k == dh) begin
        irq = r_irq; mret = r_mret; jump_valid = r_jv;
        mtvec = r_mtvec; mepc = r_mepc; jump_target = r_jt;
      end
      @(negedge clk);
      chk("hold_inst_valid", inst_valid, 1);
      chk("hold_arvalid", arvalid, 0);
      chk("hold_rready", rready, 0);
      chk("hold_inst", inst, m_inst);
      chk("hold_pcD", pcD, m_pcd);
      chk("hold_pc_plus_4D", pc_plus_4D, m_pcd + 32'd4);
      chk("hold_fetch_err", fetch_err, m_err);
      h_inst = inst; h_pcd = pcD; h_p4 = pc_plus_4D;
      tick();
    end
    if (r_irq)      sel = r_mtvec;
    else if (r_mret) sel = r_mepc;
    else if (r_jv)   sel = r_jt;
    else             sel = m_pc + 32'd4;
    m_pc = {sel[31:2], 2'b00};
  endtask

  task automatic seq_fetch(input int da, input int dr, input int dh);
    do_fetch(da, dr, dh, $urandom, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    noise();
    do_reset();

    // Zero-wait fetch
    do_fetch(0, 0, 0, 32'h0000_0013, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_araddr0", q_araddr0, 32'h8000_0000);
    chk("t1_latency", h_at, 2);
    chk("t1_inst", h_inst, 32'h0000_0013);
    chk("t1_pcD", h_pcd, 32'h8000_0000);
    chk("t1_p4", h_p4, 32'h8000_0004);

    // arready stalled 4 cycles, rvalid delayed 3
    do_fetch(4, 3, 0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_araddr0", q_araddr0, 32'h8000_0004);
    chk("t2_latency", h_at, 9);
    chk("t2_pcD", h_pcd, 32'h8000_0004);

    // Redirect priority
    do_fetch(0, 0, 0, $urandom, 2'b00, 1, 1, 1, 32'h8000_0100, 32'h8000_0300, 32'h8000_0400, 0);
    do_fetch(0, 0, 0, $urandom, 2'b00, 0, 1, 1, 32'h8000_0100, 32'h8000_0203, 32'h8000_0400, 0);
    chk("t3_irq_target", q_araddr0, 32'h8000_0100);
    seq_fetch(0, 0, 0);
    chk("t3_mret_target", q_araddr0, 32'h8000_0200);

    // jump_valid outside the handshake is ignored
    force_jv = 1'b1;
    do_fetch(1, 2, 2, $urandom, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    force_jv = 1'b0;
    seq_fetch(0, 0, 0);
    chk("t4_sequential", q_araddr0, 32'h8000_0208);

    // Error response and sticky flag
    do_fetch(0, 1, 0, 32'hdead_beef, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err_inst", h_inst, 32'h0010_0073);
    for (int n = 0; n < 10; n++) seq_fetch(0, 0, 0);
    @(negedge clk);
    chk("t5_err_sticky", fetch_err, 1);
    tick();
    do_reset();

    // Reset while waiting for read data
    do_fetch(1, 2, 0, $urandom, 2'b00, 0, 0, 0, 0, 0, 0, 1);

    // PC wraparound
    do_fetch(0, 0, 0, $urandom, 2'b00, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 0);
    seq_fetch(0, 0, 0);
    chk("t7_p4_wrap", h_p4, 32'h0000_0000);
    seq_fetch(0, 0, 0);
    chk("t7_araddr_wrap", q_araddr0, 32'h0000_0000);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom, ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom,
               ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060171_ifu.md
# ysyx_23060171_ifu

Instruction fetch unit for the multicycle ysyx_23060171 core. It holds the architectural PC and issues one instruction read per instruction over an AXI4-Lite-style read channel. It hands the fetched word, with `pcD` and `pc_plus_4D`, to the decode stage through a valid/ready handshake. It takes the next-PC decision (trap entry via `mtvec`, `mret` via `mepc`, resolved jump/branch, or sequential) back from decode/execute in the handshake cycle.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC loaded by reset.
- `ERR_INST`, default `32'h0010_0073` (ebreak): word delivered when a fetch returns an error response.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `araddr`  out  32  fetch address (equals current PC).
- `arvalid`  out  1  read request valid.
- `arready`  in  1  read request accepted.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response; any value other than `2'b00` is an error.
- `rvalid`  in  1  read data valid.
- `rready`  out  1  ready for read data.
- `inst`  out  32  fetched instruction to decode.
- `pcD`  out  32  PC of `inst`.
- `pc_plus_4D`  out  32  `pcD + 4`.
- `inst_valid`  out  1  `inst`/`pcD` are valid.
- `inst_ready`  in  1  decode consumes the instruction this cycle.
- `irq`  in  1  trap entry for the current instruction.
- `mtvec`  in  32  trap vector.
- `mret`  in  1  current instruction is `mret`.
- `mepc`  in  32  return address.
- `jump_valid`  in  1  taken jump/branch for the current instruction.
- `jump_target`  in  32  jump/branch target.
- `fetch_err`  out  1  sticky error flag.

## Operation
- Three-state FSM.
  - `REQ`: `arvalid=1`, `araddr=pc`, `rready=0`. `arvalid && arready` → `WAIT`.
  - `WAIT`: `rready=1`. `rvalid` → capture `inst`, `pcD=pc`, `pc_plus_4D=pc+4`, then go to `HOLD`.
  - `HOLD`: `inst_valid=1`. `inst_ready` → `pc <= next_pc`, then go to `REQ`.
- `next_pc` priority: `irq` → `mtvec`; else `mret` → `mepc`; else `jump_valid` → `jump_target`; else `pc+4`. Bits [1:0] of the selected value are forced to 0.
- Redirect inputs are sampled only in the `HOLD` cycle in which `inst_ready=1`. They are ignored in every other cycle.
- `araddr` remains stable while `arvalid=1` and `arready=0`. `arvalid` is never dropped before acceptance.
- `inst`, `pcD`, and `pc_plus_4D` remain stable throughout `HOLD`.
- On `rvalid` with `rresp!=0`:
  - `inst <= ERR_INST`;
  - `fetch_err <= 1`, held until `rst`;
  - `pcD` is still the faulting PC.
- `rvalid` in `REQ` or `HOLD` is not acknowledged (`rready=0`).
- PC arithmetic is 32-bit modulo. `32'hFFFF_FFFC + 4` wraps to `0`.

## Timing
- Reset (`rst` high at an edge) → state `REQ` with:
  - `pc=RESET_PC`, `araddr=RESET_PC`, `arvalid=1`;
  - `rready=0`, `inst_valid=0`;
  - `inst=0`, `pcD=RESET_PC`, `pc_plus_4D=RESET_PC+4`;
  - `fetch_err=0`.
- Reset mid-transaction abandons any outstanding read. The memory side shares `rst`.
- Minimum latency with `arready` and `rvalid` both asserted immediately: `REQ` (cycle 0), `WAIT` (cycle 1), `inst_valid` (cycle 2).
- Throughput: 3 cycles per instruction when `inst_ready` is asserted in the first `HOLD` cycle.
- Each wait cycle on `arready`, `rvalid`, or `inst_ready` adds exactly one cycle.
- `arvalid`, `rready`, and `inst_valid` are decoded from state only. They have no combinational path from any input.
- The redirect takes effect on the `araddr` presented in the first `REQ` cycle after the handshake.

## Configuration
- `YSYX_23060171_IFU_PERF_EN` defined adds two output ports:
  - `perf_fetch_cnt [63:0]`: increments on each `inst_valid && inst_ready`;
  - `perf_wait_cyc [63:0]`: increments on each `WAIT` cycle without `rvalid`.
  - Both reset to 0 and wrap at 2^64.
- `YSYX_23060171_IFU_PERF_EN` undefined: neither port nor the counters exist. All other behaviour is identical.

## Test plan
- Reset, then a zero-wait memory returning `32'h0000_0013`, with `inst_ready=1` → `araddr=32'h8000_0000` in cycle 0; `inst_valid` in cycle 2 with `pcD=32'h8000_0000` and `pc_plus_4D=32'h8000_0004`; next `araddr=32'h8000_0004` in cycle 3.
- `arready` held low for 4 cycles, `rvalid` delayed 3 cycles → `araddr` stable and `arvalid` held; `inst_valid` in cycle 9; `pcD` correct.
- In the handshake cycle, assert `irq=1`, `mret=1`, and `jump_valid=1` together with `mtvec=32'h8000_0100` → next `araddr=32'h8000_0100`. Repeat with `irq=0` and `mepc=32'h8000_0203` → next `araddr=32'h8000_0200`.
- `jump_valid=1` asserted during `WAIT` and during a `HOLD` cycle with `inst_ready=0` → ignored; sequential `pc+4` is fetched.
- `rresp=2'b10` → `inst=32'h0010_0073`; `fetch_err=1`, still set after 10 more good fetches; cleared by `rst`.
- `rst` asserted while in `WAIT` → next cycle is `REQ` with `araddr=RESET_PC`; a late `rvalid` in that cycle is not acknowledged.
